// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares the register file write port (WE3/A3/WD3) among NREQ sources.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module regfile_wb_arbiter #(
    parameter int NREQ          = 3,
    parameter int width         = 32,
    parameter int address_lines = 5,
    parameter int SRC_W         = 2
) (
    input  logic                          clk,
    input  logic                          areset,
    input  logic                          stall,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ*address_lines-1:0] req_addr,
    input  logic [NREQ*width-1:0]         req_data,
    output logic [NREQ-1:0]               req_ready,
    output logic                          WE3,
    output logic [address_lines-1:0]      A3,
    output logic [width-1:0]              WD3,
    output logic [SRC_W-1:0]              wr_src,
    output logic                          busy
);

    logic                     w_any_valid;
    logic [SRC_W-1:0]         w_grant_idx;
    logic                     w_grant;
    logic                     w_write;
    logic [address_lines-1:0] w_grant_addr;
    logic [width-1:0]         w_grant_data;

    logic                     r_we3;
    logic [address_lines-1:0] r_a3;
    logic [width-1:0]         r_wd3;
    logic [SRC_W-1:0]         r_wr_src;

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic [SRC_W-1:0]         r_rr_ptr;

    // Round-robin search: first valid requester at or after r_rr_ptr, wrapping at NREQ-1.
    always_comb begin
        int j;
        w_any_valid = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(r_rr_ptr) + k;
            j = (j >= NREQ) ? (j - NREQ) : j;
            w_grant_idx = (req_valid[j] && !w_any_valid) ? SRC_W'(j) : w_grant_idx;
            w_any_valid = w_any_valid | req_valid[j];
        end
    end

    // Pointer moves past every granted requester, x0 writes included.
    always_ff @(posedge clk) begin
        if (!areset) begin
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_rr_ptr <= (int'(w_grant_idx) == NREQ - 1) ? '0 : (w_grant_idx + SRC_W'(1));
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end
`else
    // Fixed priority search: the lowest valid index wins.
    always_comb begin
        w_any_valid = 1'b0;
        w_grant_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_grant_idx = req_valid[k] ? SRC_W'(k) : w_grant_idx;
            w_any_valid = w_any_valid | req_valid[k];
        end
    end
`endif

    // Select the winning requester's address and data.
    always_comb begin
        w_grant_addr = '0;
        w_grant_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_grant_addr = (w_grant_idx == SRC_W'(i)) ? req_addr[i*address_lines +: address_lines] : w_grant_addr;
            w_grant_data = (w_grant_idx == SRC_W'(i)) ? req_data[i*width +: width] : w_grant_data;
        end
    end

    // Reset gates ready combinationally so no handshake can occur while it is held.
    assign w_grant   = w_any_valid && areset && !stall;
    assign w_write   = w_grant && (w_grant_addr != '0);
    assign req_ready = w_grant ? ({{(NREQ-1){1'b0}}, 1'b1} << w_grant_idx) : '0;
    assign busy      = |(req_valid & ~req_ready);

    // Registered write port; x0 grants finish the handshake but leave A3/WD3/wr_src untouched.
    always_ff @(posedge clk) begin
        if (!areset) begin
            r_we3    <= 1'b0;
            r_a3     <= '0;
            r_wd3    <= '0;
            r_wr_src <= '0;
        end else if (w_write) begin
            r_we3    <= 1'b1;
            r_a3     <= w_grant_addr;
            r_wd3    <= w_grant_data;
            r_wr_src <= w_grant_idx;
        end else begin
            r_we3    <= 1'b0;
            r_a3     <= r_a3;
            r_wd3    <= r_wd3;
            r_wr_src <= r_wr_src;
        end
    end

    assign WE3    = r_we3;
    assign A3     = r_a3;
    assign WD3    = r_wd3;
    assign wr_src = r_wr_src;

endmodule
